// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace buffer.
//   trace_state_e : capture FSM states (encoding visible on the state port)
//   entry_w()     : width of one packed trace entry
// Entry layout, MSB->LSB: {cyc, pc, instr[31:0], regwrite, rd[4:0], data}
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } trace_state_e;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned REGW_W  = 1;

    function automatic int unsigned entry_w(input int unsigned cyc_w,
                                            input int unsigned pc_w,
                                            input int unsigned data_w);
        return cyc_w + pc_w + INSTR_W + REGW_W + RD_W + data_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// DEPTH x WIDTH flop storage for trace entries.
//   i_clk            clock
//   i_we/i_waddr     write enable / write address
//   i_wdata          write data
//   i_raddr/o_rdata  asynchronous read port
// Data flops carry no reset; validity is tracked by the owner's count.
module trace_ram
    import pipe_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace capture: records per-cycle snapshots of IF pc/instr and WB
// rd/regwrite/data with a timestamp, with PC trigger + post-trigger count,
// ring or stop-on-full capture, and oldest-first valid/ready drain.
//   i_clk, i_resetl                 clock, async active-low reset
//   i_arm, i_force_stop             capture control pulses
//   i_trig_en, i_trig_pc, i_post_cnt trigger setup (post_cnt latched at trigger)
//   i_smp_*                         snapshot inputs
//   o_rd_valid/i_rd_ready/o_rd_data/o_rd_last  drain port
//   o_state, o_count, o_triggered, o_cycle     status
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PC_W    = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CYC_W   = 32,
    parameter bit          WRAP    = 1'b1,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned ENTRY_W = entry_w(CYC_W, PC_W, DATA_W)
) (
    input  logic               i_clk,
    input  logic               i_resetl,
    input  logic               i_arm,
    input  logic               i_force_stop,
    input  logic               i_trig_en,
    input  logic [PC_W-1:0]    i_trig_pc,
    input  logic [AW:0]        i_post_cnt,
    input  logic               i_smp_valid,
    input  logic [PC_W-1:0]    i_smp_pc,
    input  logic [31:0]        i_smp_instr,
    input  logic               i_smp_wb_regwrite,
    input  logic [4:0]         i_smp_wb_rd,
    input  logic [DATA_W-1:0]  i_smp_wb_data,
    output logic               o_rd_valid,
    input  logic               i_rd_ready,
    output logic [ENTRY_W-1:0] o_rd_data,
    output logic               o_rd_last,
    output logic [1:0]         o_state,
    output logic [AW:0]        o_count,
    output logic               o_triggered,
    output logic [CYC_W-1:0]   o_cycle
);

    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] FULL_M1 = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    trace_state_e      r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [AW:0]       r_rem;
    logic              r_triggered;
    logic [CYC_W-1:0]  r_cycle;

    logic              w_capturing;
    logic              w_full;
    logic              w_hit;
    logic              w_we;
    logic              w_drop;
    logic              w_rd_valid;
    logic              w_pop;
    logic [ENTRY_W-1:0] w_wdata;

    assign w_capturing = (r_state == StArmed) || (r_state == StPost);
    assign w_full      = (r_count == FULL);
    assign w_hit       = i_trig_en && (i_smp_pc == i_trig_pc);
    // Control pulses suppress that cycle's sample.
    assign w_drop      = w_capturing && i_smp_valid && !WRAP && w_full;
    assign w_we        = w_capturing && i_smp_valid && !i_force_stop && !i_arm && !w_drop;
    assign w_rd_valid  = (r_state == StDone) && (r_count != '0);
    assign w_pop       = w_rd_valid && i_rd_ready;
    assign w_wdata     = {r_cycle, i_smp_pc, i_smp_instr, i_smp_wb_regwrite, i_smp_wb_rd,
                          i_smp_wb_data};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (o_rd_data)
    );

    always_ff @(posedge i_clk or negedge i_resetl) begin
        if (!i_resetl) begin
            r_state     <= StIdle;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rem       <= '0;
            r_triggered <= 1'b0;
            r_cycle     <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (i_force_stop) begin
                r_state <= StDone;
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_count  <= r_count - ONE;
                end
            end else if (i_arm) begin
                r_state     <= StArmed;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_triggered <= 1'b0;
            end else begin
                case (r_state)
                    StArmed, StPost: begin
                        if (w_drop) begin
                            r_state <= StDone;
                        end else if (w_we) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            // Ring full: oldest entry is overwritten, read side follows.
                            if (w_full) begin
                                r_rd_ptr <= r_rd_ptr + 1'b1;
                            end else begin
                                r_count <= r_count + ONE;
                            end
                            if (r_state == StArmed && w_hit) begin
                                r_triggered <= 1'b1;
                                r_rem       <= i_post_cnt;
                                r_state     <= (i_post_cnt == '0) ? StDone : StPost;
                            end else if (r_state == StPost) begin
                                r_rem <= r_rem - ONE;
                                if (r_rem == ONE) begin
                                    r_state <= StDone;
                                end
                            end
                            // Stop-on-full: the write that fills the buffer ends capture.
                            if (!WRAP && r_count == FULL_M1) begin
                                r_state <= StDone;
                            end
                        end
                    end
                    StDone: begin
                        if (w_pop) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                            r_count  <= r_count - ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_rd_valid  = w_rd_valid;
    assign o_rd_last   = w_rd_valid && (r_count == ONE);
    assign o_state     = r_state;
    assign o_count     = r_count;
    assign o_triggered = r_triggered;
    assign o_cycle     = r_cycle;

endmodule
